// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin share of the LC-3 register file write port and read-capture port.
// Ports: Clk/Reset (async, active-high); req/we/addr/wdata per requester in;
// rf_rdata from the read-capture register; gnt/done per requester, rdata,
// SR/DR/rf_din/LD_REG/LD_RD toward the register file.
module regfile_arbiter #(
    parameter int W = 16,
    parameter int A = 3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         req0,
    input  logic         we0,
    input  logic [A-1:0] addr0,
    input  logic [W-1:0] wdata0,
    input  logic         req1,
    input  logic         we1,
    input  logic [A-1:0] addr1,
    input  logic [W-1:0] wdata1,
    input  logic [W-1:0] rf_rdata,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] rdata,
    output logic [A-1:0] SR,
    output logic [A-1:0] DR,
    output logic [W-1:0] rf_din,
    output logic         LD_REG,
    output logic         LD_RD
);
    typedef enum logic [1:0] {IDLE, WR, RD_CAP, RD_RESP} state_t;

    state_t       state_q, state_d;
    logic         prio_q, prio_d;
    logic         owner_q, owner_d;
    logic         we_q, we_d;
    logic [A-1:0] addr_q, addr_d;
    logic [W-1:0] wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (req0 || req1) begin
                // on contention the prio bit picks; otherwise the lone requester wins
                owner_d = (req0 && req1) ? prio_q : req1;
                we_d    = owner_d ? we1 : we0;
                addr_d  = owner_d ? addr1 : addr0;
                wdata_d = owner_d ? wdata1 : wdata0;
                state_d = we_d ? WR : RD_CAP;
            end
            WR: begin
                prio_d  = ~owner_q;
                state_d = IDLE;
            end
            RD_CAP:  state_d = RD_RESP;
            default: begin
                prio_d  = ~owner_q;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    logic active, done;
    assign active = state_q != IDLE;
    assign done   = (state_q == WR) || (state_q == RD_RESP);
    assign gnt0   = active && !owner_q;
    assign gnt1   = active && owner_q;
    assign done0  = done && !owner_q;
    assign done1  = done && owner_q;
    assign LD_REG = state_q == WR;
    assign LD_RD  = state_q == RD_CAP;
    assign DR     = LD_REG ? addr_q : '0;
    assign rf_din = LD_REG ? wdata_q : '0;
    assign SR     = LD_RD ? addr_q : '0;
    assign rdata  = (state_q == RD_RESP) ? rf_rdata : '0;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed self-checking bench for regfile_arbiter.
module tb_regfile_arbiter;
    logic        Clk, Reset, init;
    logic        req0, we0, req1, we1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [15:0] rf_rdata, rdata, rf_din;
    logic        gnt0, gnt1, done0, done1, LD_REG, LD_RD;
    logic [2:0]  SR, DR;
    logic [15:0] regs [8];
    logic [15:0] cap;
    int checks = 0;
    int errors = 0;

    regfile_arbiter #(.W(16), .A(3)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rf_rdata(rf_rdata),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .SR(SR), .DR(DR), .rf_din(rf_din),
        .LD_REG(LD_REG), .LD_RD(LD_RD)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] init_val(input int i);
        return (i == 5) ? 16'h1234 : 16'h1000 + 16'(i);
    endfunction

    // register file with its read-capture register, as the arbiter sees it
    always @(posedge Clk) begin
        if (init) begin
            for (int i = 0; i < 8; i++) regs[i] <= init_val(i);
            cap <= '0;
        end else begin
            if (LD_REG) regs[DR] <= rf_din;
            if (LD_RD) cap <= regs[SR];
        end
    end
    assign rf_rdata = cap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {8'(gnt0), 8'(gnt1), 8'(done0), 8'(done1)} | 32'({LD_REG, LD_RD, SR, DR})
             | 32'(rf_din) | 32'(rdata);
    endfunction

    initial begin
        Reset = 1; init = 1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (2) @(negedge Clk);
        chk("reset_outputs", all_out(), 0);
        Reset = 0; init = 0;
        @(negedge Clk);
        req0 = 1; we0 = 1; addr0 = 3; wdata0 = 16'hBEEF;
        @(negedge Clk);
        chk("wr_ld_reg", 32'(LD_REG), 1);
        chk("wr_dr", 32'(DR), 3);
        chk("wr_din", 32'(rf_din), 32'hBEEF);
        chk("wr_gnt_done", 32'({gnt0, gnt1, done0, done1}), 32'b1010);
        chk("wr_sr_rdata_ldrd", 32'({LD_RD, SR, rdata}), 0);
        req0 = 0;
        @(negedge Clk);
        chk("wr_idle", 32'({gnt0, gnt1, LD_REG, done0}), 0);
        chk("wr_r3", 32'(regs[3]), 32'hBEEF);
        // prio now favours requester 1; reset mid-read must restore it to 0
        req0 = 1; we0 = 0; addr0 = 1;
        @(negedge Clk);
        chk("rst_pre_ld_rd", 32'(LD_RD), 1);
        #2 Reset = 1;
        #1 chk("rst_async_outputs", all_out(), 0);
        req0 = 0;
        @(negedge Clk);
        Reset = 0;
        repeat (3) begin
            @(negedge Clk);
            chk("rst_no_done", 32'({done0, done1, gnt0, gnt1, LD_RD, LD_REG}), 0);
        end
        // contention: both reads held high, expect 0,1,0,1
        req0 = 1; we0 = 0; addr0 = 1;
        req1 = 1; we1 = 0; addr1 = 5;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            chk("ct_gnt", 32'({gnt0, gnt1}), k[0] ? 32'b01 : 32'b10);
            chk("ct_ld_rd", 32'({LD_RD, LD_REG}), 32'b10);
            chk("ct_sr", 32'(SR), k[0] ? 5 : 1);
            @(negedge Clk);
            chk("ct_done", 32'({done0, done1, gnt0, gnt1}), k[0] ? 32'b0101 : 32'b1010);
            chk("ct_rdata", 32'(rdata), k[0] ? 32'h1234 : 32'h1001);
            @(negedge Clk);
            chk("ct_idle", 32'({gnt0, gnt1, done0, done1, LD_RD}), 0);
        end
        req0 = 0; req1 = 0;
        @(negedge Clk);
        chk("ct_quiet", 32'({gnt0, gnt1}), 0);
        // single read by requester 1
        req1 = 1; we1 = 0; addr1 = 5;
        @(negedge Clk);
        chk("rd_cap", 32'({gnt1, gnt0, LD_RD, done1}), 32'b1010);
        chk("rd_sr", 32'(SR), 5);
        chk("rd_rdata_early", 32'(rdata), 0);
        @(negedge Clk);
        chk("rd_done", 32'({done1, done0, LD_RD, SR}), 32'b100000);
        chk("rd_rdata", 32'(rdata), 32'h1234);
        req1 = 0;
        @(negedge Clk);
        chk("rd_idle", 32'({gnt1, done1}), 0);
        // inputs change after grant; latched values must be used
        req0 = 1; we0 = 1; addr0 = 2; wdata0 = 16'hAAAA;
        @(negedge Clk);
        addr0 = 6; wdata0 = 16'h5555; req0 = 0;
        chk("stab_dr", 32'(DR), 2);
        chk("stab_din", 32'(rf_din), 32'hAAAA);
        @(negedge Clk);
        chk("stab_r2", 32'(regs[2]), 32'hAAAA);
        chk("stab_r6", 32'(regs[6]), 32'h1006);
        // early drop of req1 on a read of the top index
        req1 = 1; we1 = 0; addr1 = 7;
        @(negedge Clk);
        req1 = 0; addr1 = 0;
        chk("drop_gnt", 32'({gnt1, LD_RD}), 32'b11);
        chk("drop_sr", 32'(SR), 7);
        @(negedge Clk);
        chk("drop_done", 32'({done1, gnt1}), 32'b11);
        chk("drop_rdata", 32'(rdata), 32'h1007);
        @(negedge Clk);
        chk("drop_idle", all_out(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    always @(negedge Clk) begin
        if (gnt0 && gnt1) begin
            errors++;
            $display("FAIL gnt_overlap got 11 expected not both");
        end
        if (LD_REG && LD_RD) begin
            errors++;
            $display("FAIL ld_overlap got 11 expected not both");
        end
    end
endmodule
